// File: rtl/pong_pkg.sv
// Shared Pong definitions: screen geometry, colour width, ball FSM states
// and direction encoding. Used by the ball engine, the paddle block and the
// frame-tick generator.
package pong_pkg;

    localparam int unsigned HD           = 640;      // visible columns
    localparam int unsigned VD           = 480;      // visible lines
    localparam int unsigned REFRESH_LINE = VD + 1;   // line on which a frame tick fires
    localparam int unsigned RGB_W        = 12;       // 4:4:4 colour
    localparam int unsigned MATH_W       = 11;       // one bit wider than coordinates

    typedef enum logic {
        SERVE = 1'b0,
        PLAY  = 1'b1
    } ball_state_t;

    // 1 = right / down, 0 = left / up
    localparam logic DIR_RIGHT = 1'b1;
    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_DOWN  = 1'b1;
    localparam logic DIR_UP    = 1'b0;

    // True when the half-open spans [a_lo, a_hi) and [b_lo, b_hi) intersect.
    function automatic logic spans_overlap(
        input logic [MATH_W-1:0] a_lo,
        input logic [MATH_W-1:0] a_hi,
        input logic [MATH_W-1:0] b_lo,
        input logic [MATH_W-1:0] b_hi
    );
        return (a_lo < b_hi) && (b_lo < a_hi);
    endfunction

endpackage

// File: rtl/pong_frame_tick.sv
// Registered once-per-frame strobe: fires one clk after the pixel tick at
// column 0 of the refresh line. Shared by the ball and paddle blocks.
module pong_frame_tick
    import pong_pkg::*;
#(
    parameter int unsigned REFRESH_Y = REFRESH_LINE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       p_tick,
    input  logic [9:0] x,
    input  logic [9:0] y,
    output logic       ftick
);

    // Register the start-of-refresh-line detect into a single-clk pulse
    always_ff @(posedge clk) begin
        if (reset)
            ftick <= 1'b0;
        else
            ftick <= p_tick && (x == 10'd0) && (y == 10'(REFRESH_Y));
    end

endmodule

// File: rtl/pong_ball_engine.sv
// Pong ball engine: serve delay, per-frame motion, wall and paddle bounce,
// miss detection with score pulses, and the ball pixel colour.
// Optional feature macro: PONG_BALL_SPEEDUP_EN (each paddle hit raises the
// speed by one up to BALL_VEL_MAX; a serve restores BALL_VEL).
module pong_ball_engine
    import pong_pkg::*;
#(
    parameter int unsigned      HD           = pong_pkg::HD,
    parameter int unsigned      VD           = pong_pkg::VD,
    parameter int unsigned      BALL_SIZE    = 8,
    parameter int unsigned      BALL_VEL     = 2,
    parameter int unsigned      BALL_VEL_MAX = 6,
    parameter int unsigned      PADDLE_L_X   = 32,
    parameter int unsigned      PADDLE_R_X   = 600,
    parameter int unsigned      PADDLE_W     = 8,
    parameter int unsigned      PADDLE_H     = 72,
    parameter int unsigned      SERVE_FRAMES = 60,
    parameter logic [RGB_W-1:0] BALL_RGB     = 12'hFFF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             p_tick,
    input  logic             visible,
    input  logic [9:0]       x,
    input  logic [9:0]       y,
    input  logic [9:0]       paddle_l_y,
    input  logic [9:0]       paddle_r_y,
    input  logic             pause,
    output logic [9:0]       ball_x,
    output logic [9:0]       ball_y,
    output logic [RGB_W-1:0] ball_rgb,
    output logic             score_l_pulse,
    output logic             score_r_pulse
);

    localparam logic [MATH_W-1:0] BS      = MATH_W'(BALL_SIZE);
    localparam logic [MATH_W-1:0] RIGHT_W = MATH_W'(HD);
    localparam logic [MATH_W-1:0] Y_BOT   = MATH_W'(VD - BALL_SIZE);
    localparam logic [MATH_W-1:0] R_FACE  = MATH_W'(PADDLE_R_X);
    localparam logic [MATH_W-1:0] L_FACE  = MATH_W'(PADDLE_L_X + PADDLE_W);
    localparam logic [MATH_W-1:0] PH      = MATH_W'(PADDLE_H);
    localparam logic [9:0]        X_CTR   = 10'(HD / 2 - BALL_SIZE / 2);
    localparam logic [9:0]        Y_CTR   = 10'(VD / 2 - BALL_SIZE / 2);

    localparam int unsigned CNT_W    = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SERVE_FRAMES - 1);

    // Speed register is sized to the ceiling so the speed-up build never wraps
    localparam int unsigned VEL_TOP = (BALL_VEL_MAX > BALL_VEL) ? BALL_VEL_MAX : BALL_VEL;
    localparam int unsigned VEL_W   = $clog2(VEL_TOP + 1);

    logic                ftick;
    ball_state_t         state;
    logic [CNT_W-1:0]    serve_cnt;
    logic                dir_x;
    logic                dir_y;
    logic [VEL_W-1:0]    vel;

    logic [MATH_W-1:0]   bx, by, pl, pr, vel_w;
    logic [9:0]          nx, ny;
    logic                ndx, ndy;
    logic                hit, miss_r, miss_l;

    pong_frame_tick #(
        .REFRESH_Y (VD + 1)
    ) u_frame_tick (
        .clk    (clk),
        .reset  (reset),
        .p_tick (p_tick),
        .x      (x),
        .y      (y),
        .ftick  (ftick)
    );

`ifndef PONG_BALL_SPEEDUP_EN
    assign vel = VEL_W'(BALL_VEL);
`endif

    assign bx    = {1'b0, ball_x};
    assign by    = {1'b0, ball_y};
    assign pl    = {1'b0, paddle_l_y};
    assign pr    = {1'b0, paddle_r_y};
    assign vel_w = MATH_W'(vel);

    // Candidate next position/direction for one motion step from the pre-tick position
    always_comb begin
        nx     = ball_x;
        ny     = ball_y;
        ndx    = dir_x;
        ndy    = dir_y;
        hit    = 1'b0;
        miss_r = 1'b0;
        miss_l = 1'b0;

        if (dir_y == DIR_DOWN) begin
            if (by + vel_w > Y_BOT) begin
                ny  = 10'(Y_BOT);
                ndy = DIR_UP;
            end else begin
                ny  = 10'(by + vel_w);
            end
        end else begin
            if (by < vel_w) begin
                ny  = '0;
                ndy = DIR_DOWN;
            end else begin
                ny  = 10'(by - vel_w);
            end
        end

        if (dir_x == DIR_RIGHT) begin
            if ((bx + BS <= R_FACE) && (bx + BS + vel_w > R_FACE) &&
                spans_overlap(by, by + BS, pr, pr + PH)) begin
                nx  = 10'(R_FACE - BS);
                ndx = DIR_LEFT;
                hit = 1'b1;
            end else if (bx + BS + vel_w > RIGHT_W) begin
                miss_r = 1'b1;
            end else begin
                nx = 10'(bx + vel_w);
            end
        end else begin
            if ((bx >= L_FACE) && (bx < L_FACE + vel_w) &&
                spans_overlap(by, by + BS, pl, pl + PH)) begin
                nx  = 10'(L_FACE);
                ndx = DIR_RIGHT;
                hit = 1'b1;
            end else if (bx < vel_w) begin
                miss_l = 1'b1;
            end else begin
                nx = 10'(bx - vel_w);
            end
        end
    end

    // Serve/play FSM with ball position, direction, speed and score pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= SERVE;
            serve_cnt     <= '0;
            ball_x        <= X_CTR;
            ball_y        <= Y_CTR;
            dir_x         <= DIR_RIGHT;
            dir_y         <= DIR_DOWN;
            score_l_pulse <= 1'b0;
            score_r_pulse <= 1'b0;
`ifdef PONG_BALL_SPEEDUP_EN
            vel           <= VEL_W'(BALL_VEL);
`endif
        end else begin
            score_l_pulse <= 1'b0;
            score_r_pulse <= 1'b0;
            if (ftick && !pause) begin
                case (state)
                    SERVE: begin
                        if (serve_cnt == CNT_LAST) begin
                            state     <= PLAY;
                            serve_cnt <= '0;
                        end else begin
                            serve_cnt <= serve_cnt + 1'b1;
                        end
                    end
                    PLAY: begin
                        if (miss_r || miss_l) begin
                            // Re-serve toward the conceding side; vertical direction kept
                            score_l_pulse <= miss_r;
                            score_r_pulse <= miss_l;
                            ball_x        <= X_CTR;
                            ball_y        <= Y_CTR;
                            dir_x         <= miss_r ? DIR_RIGHT : DIR_LEFT;
                            state         <= SERVE;
                            serve_cnt     <= '0;
`ifdef PONG_BALL_SPEEDUP_EN
                            vel           <= VEL_W'(BALL_VEL);
`endif
                        end else begin
                            ball_x <= nx;
                            ball_y <= ny;
                            dir_x  <= ndx;
                            dir_y  <= ndy;
`ifdef PONG_BALL_SPEEDUP_EN
                            if (hit) begin
                                if (int'(vel) + 1 > int'(BALL_VEL_MAX))
                                    vel <= VEL_W'(BALL_VEL_MAX);
                                else
                                    vel <= vel + 1'b1;
                            end
`endif
                        end
                    end
                    default: state <= SERVE;
                endcase
            end
        end
    end

    // Ball pixel colour for the current beam position, blanked during reset
    always_comb begin
        ball_rgb = '0;
        if (!reset && visible &&
            ({1'b0, x} >= bx) && ({1'b0, x} < bx + BS) &&
            ({1'b0, y} >= by) && ({1'b0, y} < by + BS))
            ball_rgb = BALL_RGB;
    end

endmodule

// File: tb/tb_pong_ball_engine.sv
// Self-checking bench for pong_ball_engine: scripted serve/bounce/miss runs,
// pause, pixel table, mid-play reset, and randomized frames against a
// per-frame behavioural model of the ball.
module tb_pong_ball_engine;

    logic        clk = 1'b0;
    logic        reset;
    logic        p_tick;
    logic        visible;
    logic [9:0]  x, y;
    logic [9:0]  paddle_l_y, paddle_r_y;
    logic        pause;
    logic [9:0]  ball_x, ball_y;
    logic [11:0] ball_rgb;
    logic        score_l_pulse, score_r_pulse;

    int n_vec = 0;
    int n_err = 0;

    pong_ball_engine dut (
        .clk           (clk),
        .reset         (reset),
        .p_tick        (p_tick),
        .visible       (visible),
        .x             (x),
        .y             (y),
        .paddle_l_y    (paddle_l_y),
        .paddle_r_y    (paddle_r_y),
        .pause         (pause),
        .ball_x        (ball_x),
        .ball_y        (ball_y),
        .ball_rgb      (ball_rgb),
        .score_l_pulse (score_l_pulse),
        .score_r_pulse (score_r_pulse)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- behavioural model ----------------
    int m_x, m_y, m_cnt;
    bit m_right, m_down, m_serving;

    task automatic model_reset();
        m_x = 316; m_y = 236; m_right = 1; m_down = 1; m_serving = 1; m_cnt = 0;
    endtask

    function automatic bit touches(input int ball_top, input int pad_top);
        return (ball_top + 8 > pad_top) && (ball_top < pad_top + 72);
    endfunction

    task automatic model_frame(input bit pz, input int pl, input int pr,
                               output bit sl, output bit sr);
        int nx, ny;
        bit nright, ndown;
        sl = 0; sr = 0;
        if (pz) return;
        if (m_serving) begin
            m_cnt++;
            if (m_cnt == 60) begin m_serving = 0; m_cnt = 0; end
            return;
        end
        ndown = m_down;
        ny = m_down ? m_y + 2 : m_y - 2;
        if (ny > 472) begin ny = 472; ndown = 0; end
        if (ny < 0)   begin ny = 0;   ndown = 1; end
        nright = m_right;
        if (m_right) begin
            if (m_x + 8 <= 600 && m_x + 8 + 2 > 600 && touches(m_y, pr)) begin
                nx = 592; nright = 0;
            end else if (m_x + 8 + 2 > 640) begin
                sl = 1;
            end else nx = m_x + 2;
        end else begin
            if (m_x >= 40 && m_x - 2 < 40 && touches(m_y, pl)) begin
                nx = 40; nright = 1;
            end else if (m_x - 2 < 0) begin
                sr = 1;
            end else nx = m_x - 2;
        end
        if (sl || sr) begin
            m_x = 316; m_y = 236; m_right = sl; m_serving = 1; m_cnt = 0;
        end else begin
            m_x = nx; m_y = ny; m_right = nright; m_down = ndown;
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    int last_sl;

    // One frame: strobe the refresh-line tick, sample after the update edge,
    // then one clk later to confirm pulses are single-cycle.
    task automatic run_frame(input bit pz, input int pl, input int pr);
        int sl1, sr1, sl2, sr2, bx, by;
        bit esl, esr;
        @(negedge clk);
        pause = pz; paddle_l_y = 10'(pl); paddle_r_y = 10'(pr);
        p_tick = 1; x = 10'd0; y = 10'd481;
        @(negedge clk);
        p_tick = 0; x = 10'd100; y = 10'd100;
        @(posedge clk); #1;
        sl1 = score_l_pulse; sr1 = score_r_pulse; bx = ball_x; by = ball_y;
        @(posedge clk); #1;
        sl2 = score_l_pulse; sr2 = score_r_pulse;
        model_frame(pz, pl, pr, esl, esr);
        last_sl = sl1;
        chk("ball_x", bx, m_x);
        chk("ball_y", by, m_y);
        chk("score_l_pulse", sl1, int'(esl));
        chk("score_r_pulse", sr1, int'(esr));
        chk("pulse_one_clk", sl2 | sr2, 0);
    endtask

    // A pixel tick that is not at (0, refresh line) must not advance anything.
    task automatic bogus_tick(input bit wrong_x);
        @(negedge clk);
        pause = 0; p_tick = 1;
        x = wrong_x ? 10'd1 : 10'd0;
        y = wrong_x ? 10'd481 : 10'd480;
        @(negedge clk); p_tick = 0;
        @(posedge clk); @(posedge clk); #1;
        chk("bogus_tick_x", ball_x, m_x);
        chk("bogus_tick_y", ball_y, m_y);
    endtask

    task automatic do_reset();
        @(negedge clk); reset = 1;
        @(negedge clk); @(negedge clk); reset = 0;
        model_reset();
    endtask

    typedef struct {
        int          dx;
        int          dy;
        bit          vis;
        logic [11:0] exp;
    } pix_t;
    pix_t pix_tbl[9];

    int px, py, pl_r, pr_r;

    initial begin
        pix_tbl[0] = '{0,  0,  1, 12'hFFF};
        pix_tbl[1] = '{7,  7,  1, 12'hFFF};
        pix_tbl[2] = '{3,  5,  1, 12'hFFF};
        pix_tbl[3] = '{8,  0,  1, 12'h000};
        pix_tbl[4] = '{0,  8,  1, 12'h000};
        pix_tbl[5] = '{-1, 0,  1, 12'h000};
        pix_tbl[6] = '{0,  -1, 1, 12'h000};
        pix_tbl[7] = '{0,  0,  0, 12'h000};
        pix_tbl[8] = '{7,  0,  0, 12'h000};

        reset = 1; p_tick = 0; visible = 1; x = 10'd316; y = 10'd236;
        paddle_l_y = 10'd200; paddle_r_y = 10'd400; pause = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ball_x", ball_x, 316);
        chk("reset_ball_y", ball_y, 236);
        chk("reset_rgb_blank", ball_rgb, 0);
        chk("reset_score_l", score_l_pulse, 0);
        chk("reset_score_r", score_r_pulse, 0);
        @(negedge clk); reset = 0;
        model_reset();
        #1 chk("post_reset_rgb", ball_rgb, 12'hFFF);

        // Run A: right paddle at 400 -> serve, wall clamp, paddle hit
        for (int f = 1; f <= 200; f++) begin
            run_frame(0, 200, 400);
            if (f == 60) begin chk("serve_hold_x", ball_x, 316); chk("serve_hold_y", ball_y, 236); end
            if (f == 61) begin chk("first_move_x", ball_x, 318); chk("first_move_y", ball_y, 238); end
            if (f == 60 + 118) chk("wall_reach_y", ball_y, 472);
            if (f == 60 + 119) chk("wall_clamp_y", ball_y, 472);
            if (f == 60 + 120) chk("wall_leave_y", ball_y, 470);
            if (f == 60 + 139) chk("paddle_hit_x", ball_x, 592);
            if (f == 60 + 140) chk("paddle_leave_x", ball_x, 590);
        end

        // Pause: ten frames with no motion
        px = ball_x; py = ball_y;
        for (int f = 0; f < 10; f++) begin
            run_frame(1, 200, 400);
            chk("pause_hold_x", ball_x, px);
            chk("pause_hold_y", ball_y, py);
        end
        run_frame(0, 200, 400);
        bogus_tick(1);
        bogus_tick(0);

        // Pixel table around the current ball position
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            x = 10'(m_x + pix_tbl[i].dx);
            y = 10'(m_y + pix_tbl[i].dy);
            visible = pix_tbl[i].vis;
            #1 chk($sformatf("pixel_%0d", i), ball_rgb, pix_tbl[i].exp);
        end
        visible = 1;

        // Reset mid-play for one clk
        @(negedge clk);
        reset = 1; x = 10'd316; y = 10'd236;
        @(posedge clk); #1;
        chk("midplay_reset_x", ball_x, 316);
        chk("midplay_reset_y", ball_y, 236);
        chk("midplay_reset_rgb", ball_rgb, 0);
        chk("midplay_reset_sl", score_l_pulse, 0);
        @(negedge clk); reset = 0;
        model_reset();

        // Run B: right paddle at 0 -> ball misses on the right
        do_reset();
        for (int f = 1; f <= 60 + 159 + 61; f++) begin
            run_frame(0, 200, 0);
            if (f == 60 + 158) chk("miss_reach_x", ball_x, 632);
            if (f == 60 + 159) begin
                chk("miss_score_l", last_sl, 1);
                chk("miss_recentre_x", ball_x, 316);
                chk("miss_recentre_y", ball_y, 236);
            end
            if (f == 60 + 159 + 60) chk("reserve_hold_x", ball_x, 316);
            if (f == 60 + 159 + 61) chk("reserve_heads_right", ball_x, 318);
        end

        // Randomized frames; paddles often track the ball to force hits
        do_reset();
        for (int f = 0; f < 600; f++) begin
            if ($urandom_range(0, 1) == 0) pl_r = m_y + 7 - int'($urandom_range(0, 78));
            else                           pl_r = int'($urandom_range(0, 1023));
            if ($urandom_range(0, 1) == 0) pr_r = m_y + 7 - int'($urandom_range(0, 78));
            else                           pr_r = int'($urandom_range(0, 1023));
            if (pl_r < 0) pl_r = 0;
            if (pr_r < 0) pr_r = 0;
            if ($urandom_range(0, 9) == 0) bogus_tick($urandom_range(0, 1) == 1);
            run_frame($urandom_range(0, 7) == 0, pl_r, pr_r);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pong_ball_engine.md
Name: pong_ball_engine

Overview:
- Downstream consumer of the VGA timing generator's x, y, visible and p_tick outputs.
- Owns ball state for Pong: serve delay, per-frame motion, wall and paddle bounce, miss detection and score pulses.
- Produces the ball pixel colour for the top-level RGB mux.
- Paddle positions arrive from the paddle block.

Parameters:
HD, 640, horizontal display width in pixels
VD, 480, vertical display height in lines
BALL_SIZE, 8, ball edge length in pixels (square)
BALL_VEL, 2, base speed in pixels per frame, applied on both axes
BALL_VEL_MAX, 6, speed ceiling; used only with the optional feature
PADDLE_L_X, 32, left paddle left edge x
PADDLE_R_X, 600, right paddle left edge x (this is its face)
PADDLE_W, 8, paddle width
PADDLE_H, 72, paddle height
SERVE_FRAMES, 60, frames held at centre before play
BALL_RGB, 12'hFFF, ball colour

Ports:
clk  in  1  system clock (100 MHz)
reset  in  1  synchronous, active-high reset
p_tick  in  1  pixel tick from the VGA timing generator
visible  in  1  display-area flag
x  in  10  current pixel column
y  in  10  current pixel line
paddle_l_y  in  10  left paddle top edge
paddle_r_y  in  10  right paddle top edge
pause  in  1  freezes motion and the serve counter
ball_x  out  10  ball left edge
ball_y  out  10  ball top edge
ball_rgb  out  12  BALL_RGB when the ball covers the current pixel, else 0
score_l_pulse  out  1  one-clk pulse: left player scored
score_r_pulse  out  1  one-clk pulse: right player scored

Behaviour:
- One clock domain. Reset is synchronous and active-high, sampled on clk rising edge only.
- Frame tick:
  - ftick = p_tick && x==0 && y==VD+1, registered one clk.
  - All position and state updates occur only on the registered ftick.
- Reset values:
  - ball_x = HD/2-BALL_SIZE/2 (316), ball_y = VD/2-BALL_SIZE/2 (236).
  - dir_x = right, dir_y = down, vel = BALL_VEL.
  - state = SERVE, serve count = 0, both score pulses 0.
- FSM, two states:
  - SERVE: each ftick with pause=0 increments the count. On the SERVE_FRAMES-th tick, go to PLAY; the ball does not move on that tick.
  - PLAY: each ftick with pause=0 performs one motion step.
  - pause=1 holds all state and the count. Pixel output stays live.
- Vertical step:
  - Moving down: if ball_y+vel > VD-BALL_SIZE, clamp ball_y = VD-BALL_SIZE (472) and set dir_y = up.
  - Moving up: if ball_y < vel, clamp ball_y = 0 and set dir_y = down.
  - Otherwise ball_y ± vel.
- Horizontal step, moving right, checked in priority order:
  1. Paddle hit: ball_x+BALL_SIZE <= PADDLE_R_X, ball_x+BALL_SIZE+vel > PADDLE_R_X, and vertical overlap (ball_y+BALL_SIZE > paddle_r_y and ball_y < paddle_r_y+PADDLE_H). Result: ball_x = PADDLE_R_X-BALL_SIZE, dir_x = left.
  2. Miss: ball_x+BALL_SIZE+vel > HD.
  3. Otherwise ball_x += vel.
- Horizontal step, moving left: mirror of the above.
  - Paddle face is PADDLE_L_X+PADDLE_W.
  - Hit clamps ball_x to the face.
  - Miss when ball_x < vel.
- Miss handling:
  - Assert the scoring side's pulse for exactly one clk (right miss → score_l_pulse, left miss → score_r_pulse).
  - Re-centre the ball, vel = BALL_VEL, state = SERVE, count = 0.
  - dir_x points toward the conceding player; dir_y is unchanged.
- The horizontal and vertical steps of one tick use the pre-tick position. A paddle hit and a wall clamp in the same tick both apply.
- Pixel output (combinational from registers plus x, y):
  - ball_rgb = BALL_RGB iff visible && ball_x <= x < ball_x+BALL_SIZE && ball_y <= y < ball_y+BALL_SIZE.
  - Output is 0 during reset.
- All arithmetic is 11-bit unsigned to avoid wrap. Paddle inputs are sampled at ftick.
- Reset mid-frame or mid-serve restores the reset values on the next clk edge. Any pending pulse is dropped.

Optional Feature:
- Macro: PONG_BALL_SPEEDUP_EN.
- Defined: each paddle hit sets vel = min(vel+1, BALL_VEL_MAX). Serve restores BALL_VEL.
- Undefined: vel is constant BALL_VEL and the BALL_VEL_MAX logic is absent.

Decomposition:
- Shared package pong_pkg holds:
  - HD, VD, refresh line VD+1
  - RGB width (12)
  - ball_state_t enum {SERVE, PLAY}
  - direction encoding (1 = right/down)
- Sub-module pong_frame_tick generates the registered ftick pulse from p_tick, x and y. The paddle block reuses it.

Test Plan:
- Reset → ball (316,236), SERVE. After 60 frames → PLAY with no move; next frame → (318,238).
- Diagonal run from serve → at PLAY frame 118, ball_y=472; frame 119, ball_y stays 472 with dir_y=up; frame 120, ball_y=470.
- paddle_r_y=400, PLAY frame 139 from ball_x=592 → ball_x stays 592, dir_x=left; next frame ball_x=590.
- paddle_r_y=0 → ball passes the face, reaches ball_x=632 at frame 158; frame 159 → score_l_pulse high for one clk, ball (316,236), SERVE, next serve heads right.
- pause=1 for 10 frames mid-PLAY → ball_x/ball_y unchanged. A pixel at (ball_x,ball_y) with visible=1 → ball_rgb=12'hFFF; visible=0 → 0.
- reset asserted mid-PLAY for one clk → all outputs at reset values on the next edge. With PONG_BALL_SPEEDUP_EN, three right-paddle hits → vel=5; the next serve restores vel=2.
